// File: rtl/countdown_timer.sv
// BCD mm:ss countdown driven by a resynchronised seconds square wave (s_clk), with start/pause/clear/load control.
// Optional macro ALARM_TIMEOUT_EN: the alarm self-clears after ALARM_SECS ticks spent in DONE.
module countdown_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int ALARM_SECS  = 10
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic       s_clk,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reject parameter values outside the supported range at elaboration.
  generate
    if (SYNC_STAGES < 2 || ALARM_SECS < 1 || ALARM_SECS > 255) begin : g_bad_params
      $error("countdown_timer: SYNC_STAGES must be >= 2 and ALARM_SECS within 1..255");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   tick_reg;

  state_t     state_reg, state_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] sec_reg, sec_next;
  logic       done_reg, done_next;
  logic       alarm_reg, alarm_next;
  logic       running_reg;
  logic       count_zero;
  logic [15:0] dec_value;

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], s_clk};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      tick_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] clamp5(input logic [3:0] d);
    return (d > 4'd5) ? 4'd5 : d;
  endfunction

  // One-second BCD decrement; only ever called with a non-zero count.
  function automatic logic [15:0] dec_count(input logic [7:0] m, input logic [7:0] s);
    logic [7:0] nm;
    logic [7:0] ns;
    nm = m;
    ns = s;
    if (s[3:0] != 4'd0) begin
      ns[3:0] = s[3:0] - 4'd1;
    end else if (s[7:4] != 4'd0) begin
      ns[3:0] = 4'd9;
      ns[7:4] = s[7:4] - 4'd1;
    end else begin
      ns = 8'h59;
      if (m[3:0] != 4'd0) begin
        nm[3:0] = m[3:0] - 4'd1;
      end else begin
        nm[3:0] = 4'd9;
        nm[7:4] = m[7:4] - 4'd1;
      end
    end
    return {nm, ns};
  endfunction

  assign count_zero = (min_reg == 8'h00) && (sec_reg == 8'h00);
  assign dec_value  = dec_count(min_reg, sec_reg);

`ifdef ALARM_TIMEOUT_EN
  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);
  logic [7:0] acnt_reg, acnt_next;

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      acnt_reg <= 8'd0;
    end else begin
      acnt_reg <= acnt_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    done_next  = 1'b0;
    alarm_next = alarm_reg;
`ifdef ALARM_TIMEOUT_EN
    acnt_next  = acnt_reg;
`endif
    if (clear) begin
      min_next   = 8'h00;
      sec_next   = 8'h00;
      state_next = IDLE;
      alarm_next = 1'b0;
    end else if (load && state_reg != RUN) begin
      min_next   = {clamp9(preset_min[7:4]), clamp9(preset_min[3:0])};
      sec_next   = {clamp5(preset_sec[7:4]), clamp9(preset_sec[3:0])};
      state_next = IDLE;
      alarm_next = 1'b0;
    end else if (start && (state_reg == IDLE || state_reg == PAUSE) && !count_zero) begin
      state_next = RUN;
    end else if (pause && state_reg == RUN) begin
      state_next = PAUSE;
    end else if (tick_reg) begin
      if (state_reg == RUN && !count_zero) begin
        min_next = dec_value[15:8];
        sec_next = dec_value[7:0];
        if (dec_value == 16'h0000) begin
          state_next = DONE;
          done_next  = 1'b1;
          alarm_next = 1'b1;
`ifdef ALARM_TIMEOUT_EN
          acnt_next  = 8'd0;
`endif
        end
      end
`ifdef ALARM_TIMEOUT_EN
      else if (state_reg == DONE) begin
        if (acnt_reg + 8'd1 == ALARM_LIMIT) begin
          alarm_next = 1'b0;
          state_next = IDLE;
          acnt_next  = 8'd0;
        end else begin
          acnt_next = acnt_reg + 8'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      min_reg     <= 8'h00;
      sec_reg     <= 8'h00;
      done_reg    <= 1'b0;
      alarm_reg   <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      min_reg     <= min_next;
      sec_reg     <= sec_next;
      done_reg    <= done_next;
      alarm_reg   <= alarm_next;
      running_reg <= (state_next == RUN);
    end
  end

  assign min_bcd = min_reg;
  assign sec_bcd = sec_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign alarm   = alarm_reg;
  assign state   = state_reg;

endmodule
